// File: rtl/cycle_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : cycle_sequencer_if
// Description : Bus bundle between the machine-cycle sequencer and the
//               ROM / decoder side of the core.
//                 romData    - ROM nibble bus into the sequencer
//                 halt       - stop request, honoured only between instructions
//                 stepReq    - single-instruction step (SEQ_STEP_EN builds only)
//                 cycle      - current machine cycle (A1..X3 = 0..7)
//                 sync       - X3 marker while running
//                 opr/opa    - latched opcode / operand nibbles
//                 secondWord - second byte of a two-word instruction
//                 pcInc      - program-counter increment strobe
//                 irValid    - decoder execute window
//                 halted     - sequencer parked in HALTED
//               Modport master is the sequencer, slave is its consumer.
//               Optional feature macro: SEQ_STEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface cycle_sequencer_if;
    logic [3:0] romData;
    logic       halt;
`ifdef SEQ_STEP_EN
    logic       stepReq;
`endif
    logic [2:0] cycle;
    logic       sync;
    logic [3:0] opr;
    logic [3:0] opa;
    logic [7:0] secondWord;
    logic       pcInc;
    logic       irValid;
    logic       halted;

`ifdef SEQ_STEP_EN
    modport master (
        input  romData, halt, stepReq,
        output cycle, sync, opr, opa, secondWord, pcInc, irValid, halted
    );
    modport slave (
        output romData, halt, stepReq,
        input  cycle, sync, opr, opa, secondWord, pcInc, irValid, halted
    );
`else
    modport master (
        input  romData, halt,
        output cycle, sync, opr, opa, secondWord, pcInc, irValid, halted
    );
    modport slave (
        output romData, halt,
        input  cycle, sync, opr, opa, secondWord, pcInc, irValid, halted
    );
`endif
endinterface
`default_nettype wire

// File: rtl/cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cycle_sequencer
// Description : Eight-cycle instruction sequencer (A1 A2 A3 M1 M2 X1 X2 X3).
//               Fetches one or two ROM words per instruction, latches the
//               opcode/operand nibbles and the second word, and parks in
//               HALTED between instructions when halt is requested.
//               Ports:
//                 clk - system clock, rising-edge active
//                 rst - asynchronous active-high reset
//                 bus - cycle_sequencer_if.master (see interface header)
//               Optional feature macro: SEQ_STEP_EN adds bus.stepReq, which
//               runs exactly one instruction out of HALTED.
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_sequencer (
    input  wire                clk,
    input  wire                rst,
    cycle_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        RUN_W1 = 2'd0,
        RUN_W2 = 2'd1,
        HALTED = 2'd2
    } seqState_t;

    localparam logic [2:0] c_CYC_A1 = 3'd0;
    localparam logic [2:0] c_CYC_M1 = 3'd3;
    localparam logic [2:0] c_CYC_M2 = 3'd4;
    localparam logic [2:0] c_CYC_X1 = 3'd5;
    localparam logic [2:0] c_CYC_X3 = 3'd7;

    seqState_t  r_state;
    seqState_t  w_stateNext;
    logic [2:0] r_cycle;
    logic [2:0] w_cycleNext;
    logic [3:0] r_highNib;
    logic [3:0] r_opr;
    logic [3:0] r_opa;
    logic [7:0] r_secondWord;
    logic       w_twoWord;
    logic       w_running;
    logic       w_resume;

    // JCN, FIM (even opa only; odd opa is the single-word SRC), JUN, JMS, ISZ
    assign w_twoWord = (r_opr == 4'd1) ||
                       ((r_opr == 4'd2) && !r_opa[0]) ||
                       (r_opr == 4'd4) ||
                       (r_opr == 4'd5) ||
                       (r_opr == 4'd7);

    assign w_running = (r_state != HALTED);

`ifdef SEQ_STEP_EN
    // A step leaves HALTED even with halt held; the normal end-of-instruction
    // check then returns here after that single instruction.
    assign w_resume = !bus.halt || bus.stepReq;
`else
    assign w_resume = !bus.halt;
`endif

    // ------------------------------------------------------------------
    // State and cycle register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN_W1;
            r_cycle <= c_CYC_A1;
        end else begin
            r_state <= w_stateNext;
            r_cycle <= w_cycleNext;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        w_cycleNext = r_cycle + 3'd1;
        case (r_state)
            RUN_W1: begin
                if (r_cycle == c_CYC_X3) begin
                    // A two-word opcode always fetches its second word;
                    // halt can only take effect once the instruction is whole.
                    if (w_twoWord)
                        w_stateNext = RUN_W2;
                    else if (bus.halt)
                        w_stateNext = HALTED;
                    else
                        w_stateNext = RUN_W1;
                end
            end
            RUN_W2: begin
                if (r_cycle == c_CYC_X3)
                    w_stateNext = bus.halt ? HALTED : RUN_W1;
            end
            HALTED: begin
                // Cycle stays at A1 across the exit edge so the first A1
                // after resuming is a full clock long.
                w_cycleNext = c_CYC_A1;
                if (w_resume)
                    w_stateNext = RUN_W1;
            end
            default: begin
                w_stateNext = RUN_W1;
                w_cycleNext = c_CYC_A1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction word capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_highNib    <= 4'd0;
            r_opr        <= 4'd0;
            r_opa        <= 4'd0;
            r_secondWord <= 8'd0;
        end else begin
            if (r_state == RUN_W1) begin
                if (r_cycle == c_CYC_M1)
                    r_highNib <= bus.romData;
                // opr and opa change on the same edge so the decoder never
                // sees a mixed old/new pair.
                if (r_cycle == c_CYC_M2) begin
                    r_opr <= r_highNib;
                    r_opa <= bus.romData;
                end
            end else if (r_state == RUN_W2) begin
                if (r_cycle == c_CYC_M1)
                    r_secondWord[7:4] <= bus.romData;
                if (r_cycle == c_CYC_M2)
                    r_secondWord[3:0] <= bus.romData;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.cycle      = r_cycle;
    assign bus.opr        = r_opr;
    assign bus.opa        = r_opa;
    assign bus.secondWord = r_secondWord;
    assign bus.halted     = (r_state == HALTED);
    assign bus.sync       = w_running && (r_cycle == c_CYC_X3);
    assign bus.pcInc      = w_running && (r_cycle == c_CYC_M2);
    assign bus.irValid    = (r_cycle >= c_CYC_X1) &&
                            (((r_state == RUN_W1) && !w_twoWord) ||
                             (r_state == RUN_W2));

endmodule
`default_nettype wire

// File: tb/tb_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cycle_sequencer
// Description : Self-checking bench for cycle_sequencer. A table of
//               instruction words with hand-computed expectations is run
//               back to back, followed by directed halt, reset and (with
//               SEQ_STEP_EN) single-step sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cycle_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cycle_sequencer_if bus ();

    cycle_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [7:0] w1;
        logic [7:0] w2;
        logic       twoWord;
        logic [3:0] expOpr;
        logic [3:0] expOpa;
        logic [7:0] expSecPrev;  // secondWord visible during the first word
    } wordVec_t;

    wordVec_t vecs [0:11];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs nCyc cycles of one word starting at A1, checking every cycle.
    task automatic runWord(input logic [7:0] word, input logic expIr,
                           input logic [3:0] eOpr, input logic [3:0] eOpa,
                           input logic [7:0] eSec, input logic haltIn,
                           input int nCyc);
        for (int c = 0; c < nCyc; c++) begin
            bus.halt = haltIn;
            if (c == 3)
                bus.romData = word[7:4];
            else if (c == 4)
                bus.romData = word[3:0];
            else
                bus.romData = 4'(c) ^ 4'hA;
            chk($sformatf("cycle w%02h c%0d", word, c), 8'(bus.cycle), 8'(c));
            chk($sformatf("sync w%02h c%0d", word, c), 8'(bus.sync), 8'(c == 7));
            chk($sformatf("pcInc w%02h c%0d", word, c), 8'(bus.pcInc), 8'(c == 4));
            chk($sformatf("irValid w%02h c%0d", word, c), 8'(bus.irValid), 8'(expIr && c >= 5));
            chk($sformatf("halted w%02h c%0d", word, c), 8'(bus.halted), 8'd0);
            if (c >= 5) begin
                chk($sformatf("opr w%02h c%0d", word, c), 8'(bus.opr), 8'(eOpr));
                chk($sformatf("opa w%02h c%0d", word, c), 8'(bus.opa), 8'(eOpa));
                chk($sformatf("secondWord w%02h c%0d", word, c), bus.secondWord, eSec);
            end
            tick();
        end
    endtask

    task automatic checkHalted(input int n);
        for (int i = 0; i < n; i++) begin
            bus.halt = 1'b1;
            chk("halted flag", 8'(bus.halted), 8'd1);
            chk("halted cycle", 8'(bus.cycle), 8'd0);
            chk("halted sync", 8'(bus.sync), 8'd0);
            chk("halted pcInc", 8'(bus.pcInc), 8'd0);
            chk("halted irValid", 8'(bus.irValid), 8'd0);
            tick();
        end
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, " cycle"}, 8'(bus.cycle), 8'd0);
        chk({tag, " sync"}, 8'(bus.sync), 8'd0);
        chk({tag, " pcInc"}, 8'(bus.pcInc), 8'd0);
        chk({tag, " irValid"}, 8'(bus.irValid), 8'd0);
        chk({tag, " halted"}, 8'(bus.halted), 8'd0);
        chk({tag, " opr"}, 8'(bus.opr), 8'd0);
        chk({tag, " opa"}, 8'(bus.opa), 8'd0);
        chk({tag, " secondWord"}, bus.secondWord, 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{8'hD5, 8'h00, 1'b0, 4'hD, 4'h5, 8'h00};
        vecs[1]  = '{8'hA3, 8'h00, 1'b0, 4'hA, 4'h3, 8'h00};
        vecs[2]  = '{8'h40, 8'h12, 1'b1, 4'h4, 4'h0, 8'h00};  // JUN
        vecs[3]  = '{8'h22, 8'h77, 1'b1, 4'h2, 4'h2, 8'h12};  // FIM R2
        vecs[4]  = '{8'h23, 8'h00, 1'b0, 4'h2, 4'h3, 8'h77};  // SRC
        vecs[5]  = '{8'h10, 8'h34, 1'b1, 4'h1, 4'h0, 8'h77};  // JCN
        vecs[6]  = '{8'h5C, 8'h9E, 1'b1, 4'h5, 4'hC, 8'h34};  // JMS
        vecs[7]  = '{8'h7F, 8'h01, 1'b1, 4'h7, 4'hF, 8'h9E};  // ISZ
        vecs[8]  = '{8'h30, 8'h00, 1'b0, 4'h3, 4'h0, 8'h01};
        vecs[9]  = '{8'h60, 8'h00, 1'b0, 4'h6, 4'h0, 8'h01};
        vecs[10] = '{8'h21, 8'h00, 1'b0, 4'h2, 4'h1, 8'h01};
        vecs[11] = '{8'hF0, 8'h00, 1'b0, 4'hF, 4'h0, 8'h01};

        bus.romData = 4'h0;
        bus.halt    = 1'b0;
`ifdef SEQ_STEP_EN
        bus.stepReq = 1'b0;
`endif

        // Reset state
        #1;
        checkAllZero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        checkAllZero("reset held");
        rst = 1'b0;

        // Instruction table
        for (int i = 0; i < 12; i++) begin
            runWord(vecs[i].w1, !vecs[i].twoWord, vecs[i].expOpr, vecs[i].expOpa,
                    vecs[i].expSecPrev, 1'b0, 8);
            if (vecs[i].twoWord)
                runWord(vecs[i].w2, 1'b1, vecs[i].expOpr, vecs[i].expOpa,
                        vecs[i].w2, 1'b0, 8);
        end

        // halt raised during the first word of JMS: the second word is still fetched
        runWord(8'h53, 1'b0, 4'h5, 4'h3, 8'h01, 1'b1, 8);
        runWord(8'h21, 1'b1, 4'h5, 4'h3, 8'h21, 1'b1, 8);
        checkHalted(3);
        bus.halt = 1'b0;
        chk("exit edge halted", 8'(bus.halted), 8'd1);
        tick();
        runWord(8'hA3, 1'b1, 4'hA, 4'h3, 8'h21, 1'b0, 8);

        // halt on a single-word instruction
        runWord(8'h23, 1'b1, 4'h2, 4'h3, 8'h21, 1'b1, 8);
        checkHalted(2);
        bus.halt = 1'b0;
        tick();
        runWord(8'hD5, 1'b1, 4'hD, 4'h5, 8'h21, 1'b0, 8);

        // Reset mid-way through the second word of JUN
        runWord(8'h40, 1'b0, 4'h4, 4'h0, 8'h21, 1'b0, 8);
        runWord(8'h12, 1'b1, 4'h4, 4'h0, 8'h12, 1'b0, 6);
        chk("pre-reset cycle", 8'(bus.cycle), 8'd6);
        chk("pre-reset irValid", 8'(bus.irValid), 8'd1);
        rst = 1'b1;
        #1;
        checkAllZero("async reset");
        tick();
        rst = 1'b0;
        #1;
        runWord(8'hD5, 1'b1, 4'hD, 4'h5, 8'h00, 1'b0, 8);

`ifdef SEQ_STEP_EN
        // One step with halt held runs exactly one two-word instruction
        runWord(8'hA3, 1'b1, 4'hA, 4'h3, 8'h00, 1'b1, 8);
        checkHalted(2);
        bus.halt    = 1'b1;
        bus.stepReq = 1'b1;
        tick();
        bus.stepReq = 1'b0;
        runWord(8'h14, 1'b0, 4'h1, 4'h4, 8'h00, 1'b1, 8);
        runWord(8'h20, 1'b1, 4'h1, 4'h4, 8'h20, 1'b1, 8);
        checkHalted(3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 SHALL have one clock, clk; reset is asynchronous and active-high, named rst.
REQ-002 SHALL have port: clk  in  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous active-high reset.
REQ-004 SHALL have port: romData  in  4  ROM nibble bus, sampled at the end of M1 and M2.
REQ-005 SHALL have port: halt  in  1  stop request, sampled only at the end of an instruction.
REQ-006 SHALL have port: cycle  out  3  machine cycle (A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7), registered.
REQ-007 SHALL have port: sync  out  1  high during X3 while running, marking the next A1.
REQ-008 SHALL have port: opr  out  4  latched opcode nibble.
REQ-009 SHALL have port: opa  out  4  latched operand nibble.
REQ-010 SHALL have port: secondWord  out  8  D2D1 byte of a two-word instruction.
REQ-011 SHALL have port: pcInc  out  1  one-clock program-counter increment strobe.
REQ-012 SHALL have port: irValid  out  1  decoder execute window for the current instruction.
REQ-013 SHALL have port: halted  out  1  high while in HALTED.

Function
REQ-014 SHALL implement states RUN_W1 (first word), RUN_W2 (second word) and HALTED.
REQ-015 SHALL, while running, advance cycle 0..7 by 1 per clock and wrap from 7 to 0.
REQ-016 SHALL, in HALTED, hold cycle at 0.
REQ-017 SHALL, in RUN_W1, capture romData into an internal high nibble at the end of M1.
REQ-018 SHALL, in RUN_W1 at the end of M2, update opr and opa together: opr from the captured high nibble, opa from romData.
REQ-019 SHALL classify as two-word: opr=1 (JCN), 2 with opa[0]=0 (FIM), 4 (JUN), 5 (JMS), 7 (ISZ).
REQ-020 SHALL, in RUN_W2, leave opr/opa unchanged, load secondWord[7:4] at the end of M1 and secondWord[3:0] at the end of M2.
REQ-021 SHALL hold secondWord unchanged in RUN_W1.
REQ-022 SHALL assert pcInc combinationally when cycle=4 and the state is not HALTED, once per word.
REQ-023 SHALL assert sync combinationally when cycle=7 and the state is not HALTED.
REQ-024 SHALL assert irValid when cycle is 5..7 and either (RUN_W1 and opr is single-word) or RUN_W2.
REQ-025 SHALL, at the end of X3 in RUN_W1 with two-word opr, go to RUN_W2 regardless of halt; halt never splits an instruction.
REQ-026 SHALL, at the end of X3 of a completed instruction (single-word in RUN_W1, or RUN_W2): go to HALTED if halt=1, else to RUN_W1.
REQ-027 SHALL, in HALTED with halt=0, go to RUN_W1 on the next edge with cycle=0; A1 then lasts one full clock.
REQ-028 SHALL ignore halt at all other cycles.

Reset
REQ-029 SHALL, while rst=1, asynchronously set: state RUN_W1, cycle=0, opr=0, opa=0, secondWord=0, internal nibble=0.
REQ-030 SHALL, as a consequence of REQ-029, drive sync=0, pcInc=0, irValid=0, halted=0 during reset.
REQ-031 SHALL, on reset asserted mid-instruction (any state or cycle), abandon it and restart at A1 of RUN_W1 after release.

Configuration
REQ-032 SHALL, with SEQ_STEP_EN defined, add input stepReq (1 bit).
REQ-033 SHALL, with SEQ_STEP_EN, treat a stepReq=1 clock in HALTED (even with halt=1) as a step: run exactly one complete instruction (both words if two-word), then re-enter HALTED if halt=1.
REQ-034 SHALL, with SEQ_STEP_EN, ignore stepReq outside HALTED.
REQ-035 SHALL, without SEQ_STEP_EN, have no stepReq port, and HALTED exits only via halt=0.

Verification
REQ-036 SHALL cover: reset release, ROM words 0xD5 then 0xA3 -> opr=D/opa=5 from the M2 edge, irValid cycles 5-7; then opr=A/opa=3; pcInc once per 8 clocks.
REQ-037 SHALL cover: ROM 0x40 then 0x12 (JUN) -> irValid low in the first word's X1-X3, secondWord=0x12, irValid high in the second word's X1-X3, pcInc twice.
REQ-038 SHALL cover: ROM 0x22 (FIM R2) -> RUN_W2; ROM 0x23 -> single-word.
REQ-039 SHALL cover: halt=1 during the first word of a JMS (0x5x) -> second word still fetched; HALTED after its X3, cycle=0, sync=0, pcInc=0; halt=0 -> resume at A1.
REQ-040 SHALL cover: rst pulse at cycle=6 of RUN_W2 -> all outputs zero immediately; restart at cycle 0 in RUN_W1.
REQ-041 SHALL cover (SEQ_STEP_EN): halt=1 held, one stepReq pulse with ROM 0x14,0x20 -> exactly 16 running clocks, then HALTED.
